vga_pattern_feeder: RTL and testbench
=====================================

// Module: vga_pattern_feeder
// PURPOSE
//  Producer at the write end of the pixel FIFO that feeds vga_logic (fifo_empty/pixel_in side).
//  Generates one frame of test-pattern pixels in raster order and writes them into the FIFO
//  under a full/write-enable handshake. Lets the VGA path run without a frame buffer.
//  Typical bring-up use: feeder -> pixel FIFO -> vga_logic.
// PARAMETERS
//  H_ACTIVE     640          visible pixels per line
//  V_ACTIVE     480          visible lines per frame
//  BAR_W        80           colour-bar width in pixels; H_ACTIVE == 8*BAR_W
//  CHECK_LOG2   5            checkerboard square size is 2**CHECK_LOG2 pixels
//  SOLID_COLOR  24'hFFFFFF   RGB value for solid mode
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  enable      in   1   level; high = produce frames continuously
//  mode        in   2   0 bars, 1 checker, 2 gradient, 3 solid; sampled at frame start only
//  fifo_full   in   1   FIFO cannot accept a write this cycle
//  wr_en       out  1   FIFO write strobe; pixel_out is valid while it is high
//  pixel_out   out  24  {red[7:0], green[7:0], blue[7:0]}
//  frame_done  out  1   one-cycle pulse after the last pixel of a frame is written
// BEHAVIOUR
//  Reset: state=IDLE, x=0, y=0, bar_idx=0, bar_cnt=0, mode_q=0, frame_done=0.
//   wr_en=0, pixel_out=24'h0.
//  FSM IDLE -> RUN when enable=1; mode_q<=mode on that edge.
//   RUN -> IDLE on the last-pixel write if enable=0; otherwise stay in RUN with mode_q<=mode.
//  Handshake: wr_en = (state==RUN) & ~fifo_full, combinational. A write occurs on each clock
//   edge with wr_en=1. pixel_out is a combinational function of the registered x, y and mode_q.
//   pixel_out is 0 whenever wr_en=0. Zero-latency response to fifo_full.
//  Counters advance only on a write. Order: x++. x==H_ACTIVE-1 -> x=0, y++.
//   Last pixel: x==H_ACTIVE-1 and y==V_ACTIVE-1 -> x=0, y=0, frame_done=1 next cycle.
//  Stall: fifo_full=1 holds x, y and bar state unchanged; the same pixel is presented on resume.
//  enable dropped mid-frame: the frame completes (all H_ACTIVE*V_ACTIVE pixels), then IDLE.
//   No partial frames are produced.
//  mode change mid-frame is ignored until the next frame start.
//  Bars: bar_cnt counts 0..BAR_W-1 per write. bar_idx++ on wrap and resets to 0 at x wrap.
//   No divider. Colours by bar_idx 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000,
//   0000FF, 000000.
//  Checker: (x[CHECK_LOG2]^y[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000.
//  Gradient: red=x[9:2], green=y[8:1], blue=8'h80. Truncated and never saturating.
//  Solid: SOLID_COLOR.
//  rst mid-frame: reset values apply on the next edge, so wr_en=0 in the cycle after rst.
//   The new frame restarts at (0,0).
//  fifo_full together with the last pixel: no write occurs and frame_done is not pulsed
//   until the write happens.
// STRUCTURE
//  vga_pkg (shared): mode encodings MODE_BARS/CHECK/GRAD/SOLID, 8 bar-colour constants,
//   H_ACTIVE/V_ACTIVE defaults.
//  One sub-module, vga_pattern_color: combinational (mode_q, x, y, bar_idx) -> 24-bit RGB.
//  Top holds the FSM, counters and handshake.
// TESTING
//  1 rst=1 for 2 cycles, then enable=0 -> wr_en=0, pixel_out=0, frame_done=0 indefinitely.
//  2 enable=1, mode=0, fifo_full=0 -> writes 0..79 = FFFFFF, write 80 = FFFF00,
//    write 639 = 000000, write 640 = FFFFFF (line 1).
//  3 fifo_full=1 for 5 cycles at x=100 -> wr_en=0 and x holds.
//    On release the next write carries the x=100 colour (FFFF00), with no skip or duplicate.
//  4 Full frame, mode=2 -> exactly 307200 writes, then frame_done=1 for one cycle.
//    Next write is (0,0) = 000080; pixel (639,479) = 9FEF80.
//  5 mode 0->1 at y=10 -> bars continue to frame end.
//    Frame 2 pixel (32,0) = FFFFFF and pixel (32,32) = 000000.
//  6 enable=0 at y=200 -> frame completes, frame_done pulses, IDLE, no further writes.
//    Separately, rst at y=200 -> wr_en=0 next cycle; restart begins at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared encodings for the VGA pattern path. It holds the
//               pattern-mode codes, the default active-area size and the
//               colour-bar palette.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Pattern-mode encodings. The mode is carried on a 2-bit bus.
    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_CHECK = 2'd1;
    localparam logic [1:0] MODE_GRAD  = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    // Default visible raster size (640x480 timing).
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // The eight colour-bar colours, in order from left to right. Format is {R,G,B}.
    localparam logic [23:0] c_BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] c_BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] c_BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] c_BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] c_BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] c_BAR_RED     = 24'hFF0000;
    localparam logic [23:0] c_BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] c_BAR_BLACK   = 24'h000000;

    // Look up the palette entry for a given bar index.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] v_rgb;
        case (idx)
            3'd0:    v_rgb = c_BAR_WHITE;
            3'd1:    v_rgb = c_BAR_YELLOW;
            3'd2:    v_rgb = c_BAR_CYAN;
            3'd3:    v_rgb = c_BAR_GREEN;
            3'd4:    v_rgb = c_BAR_MAGENTA;
            3'd5:    v_rgb = c_BAR_RED;
            3'd6:    v_rgb = c_BAR_BLUE;
            default: v_rgb = c_BAR_BLACK;
        endcase
        return v_rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pattern_color.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_color
// Description : Purely combinational pixel-colour generator. It maps the
//               frame's mode together with the raster position (x, y,
//               bar index) to a 24-bit {R,G,B} value.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_color
    import vga_pkg::*;
#(
    parameter int          X_W         = 10,
    parameter int          Y_W         = 9,
    parameter int          CHECK_LOG2  = 5,
    parameter logic [23:0] SOLID_COLOR = 24'hFFFFFF
) (
    input  logic [1:0]     i_mode,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic [2:0]     i_bar_idx,
    output logic [23:0]    o_rgb
);

    // Several coordinate bits feed no pattern. Fold them together here so that
    // it is clear they are deliberately left unused.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, i_x, i_y};

    // Choose the colour for the current pattern. The gradient uses plain bit
    // slices, so it wraps rather than saturates.
    always_comb begin
        o_rgb = 24'h000000;
        case (i_mode)
            MODE_BARS:  o_rgb = bar_color(i_bar_idx);
            MODE_CHECK: o_rgb = (i_x[CHECK_LOG2] ^ i_y[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            MODE_GRAD:  o_rgb = {i_x[9:2], i_y[8:1], 8'h80};
            default:    o_rgb = SOLID_COLOR;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vga_pattern_feeder.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_feeder
// Description : Writes whole frames of test-pattern pixels, in raster order,
//               into the pixel FIFO in front of vga_logic. It uses a
//               full/write-enable handshake. A frame that has started always
//               completes, and the mode is latched only at frame starts.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_feeder
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          BAR_W       = 80,
    parameter int          CHECK_LOG2  = 5,
    parameter logic [23:0] SOLID_COLOR = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [23:0] pixel_out,
    output logic        frame_done
);

    // The counters are kept at least wide enough for the fixed gradient slices
    // x[9:2] and y[8:1].
    localparam int c_X_W  = ($clog2(H_ACTIVE) > 10) ? $clog2(H_ACTIVE) : 10;
    localparam int c_Y_W  = ($clog2(V_ACTIVE) > 9)  ? $clog2(V_ACTIVE) : 9;
    localparam int c_BC_W = ($clog2(BAR_W) > 1)     ? $clog2(BAR_W)    : 1;

    localparam logic [c_X_W-1:0]  c_X_LAST  = c_X_W'(H_ACTIVE - 1);
    localparam logic [c_Y_W-1:0]  c_Y_LAST  = c_Y_W'(V_ACTIVE - 1);
    localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(BAR_W - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              w_load_mode;
    logic [1:0]        r_mode_q;
    logic [c_X_W-1:0]  r_x;
    logic [c_Y_W-1:0]  r_y;
    logic [c_BC_W-1:0] r_bar_cnt;
    logic [2:0]        r_bar_idx;
    logic              r_frame_done;

    logic              w_wr_en;
    logic              w_last_x;
    logic              w_last_px;
    logic              w_bar_wrap;
    logic [23:0]       w_rgb;

    assign w_wr_en    = (r_state == S_RUN) & ~fifo_full;
    assign w_last_x   = (r_x == c_X_LAST);
    assign w_last_px  = w_last_x & (r_y == c_Y_LAST);
    assign w_bar_wrap = (r_bar_cnt == c_BC_LAST);

    // Next-state logic. A new frame starts on leaving IDLE, or when the last
    // pixel is written while still enabled. The mode is captured at each start.
    always_comb begin
        w_state_nxt = r_state;
        w_load_mode = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                    w_load_mode = 1'b1;
                end
            end
            S_RUN: begin
                if (w_wr_en && w_last_px) begin
                    if (enable) begin
                        w_load_mode = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registers for the state, the latched mode and the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode_q     <= MODE_BARS;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_wr_en & w_last_px;
            if (w_load_mode) begin
                r_mode_q <= mode;
            end
        end
    end

    // Raster and bar counters. They move only when a write is accepted, so a
    // stall presents the same pixel again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= 3'd0;
        end else if (w_wr_en) begin
            if (w_last_x) begin
                r_x       <= '0;
                r_bar_cnt <= '0;
                r_bar_idx <= 3'd0;
                r_y       <= w_last_px ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
                if (w_bar_wrap) begin
                    r_bar_cnt <= '0;
                    r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 1'b1;
                end
            end
        end
    end

    vga_pattern_color #(
        .X_W         (c_X_W),
        .Y_W         (c_Y_W),
        .CHECK_LOG2  (CHECK_LOG2),
        .SOLID_COLOR (SOLID_COLOR)
    ) u_color (
        .i_mode    (r_mode_q),
        .i_x       (r_x),
        .i_y       (r_y),
        .i_bar_idx (r_bar_idx),
        .o_rgb     (w_rgb)
    );

    // The FIFO interface follows fifo_full with zero latency. The data bus is
    // forced to zero whenever no write is offered.
    always_comb begin
        wr_en     = w_wr_en;
        pixel_out = w_wr_en ? w_rgb : 24'h000000;
    end

    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_feeder
// Description : Self-checking bench for vga_pattern_feeder. It uses a reduced
//               raster, a frame-level reference model, directed sequences and
//               a randomized soak phase.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_pattern_feeder;

    localparam int          H     = 128;
    localparam int          V     = 48;
    localparam int          BW    = 16;
    localparam int          CL    = 3;
    localparam logic [23:0] SOLID = 24'h12A5C3;
    localparam int          NPIX  = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        fifo_full = 1'b0;
    logic        wr_en;
    logic [23:0] pixel_out;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_pattern_feeder #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .BAR_W       (BW),
        .CHECK_LOG2  (CL),
        .SOLID_COLOR (SOLID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .fifo_full  (fifo_full),
        .wr_en      (wr_en),
        .pixel_out  (pixel_out),
        .frame_done (frame_done)
    );

    logic [23:0] bar_tab [8];
    initial begin
        bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00;
        bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
        bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
        bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;
    end

    // Reference colour of pixel (x,y), computed directly from the pattern rules.
    function automatic logic [23:0] ref_color(input int md, input int x, input int y);
        case (md)
            0:       return bar_tab[x / BW];
            1:       return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2:       return {8'((x >> 2) & 255), 8'((y >> 1) & 255), 8'h80};
            default: return SOLID;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model state: is a frame running, with which mode, and which pixel is next.
    bit m_on   = 1'b0;
    bit m_run  = 1'b0;
    int m_mode = 0;
    int m_n    = 0;
    bit m_done = 1'b0;

    // Per-frame log of the pixels the DUT wrote.
    logic [23:0] pix_log [NPIX];
    int wcount = 0;
    int last_count = 0;
    int frames = 0;

    // Each cycle: compare the DUT with the model, log writes, then advance the model.
    always @(negedge clk) begin
        bit          e_wr;
        logic [23:0] e_pix;
        if (m_on) begin
            e_wr  = m_run && !fifo_full;
            e_pix = e_wr ? ref_color(m_mode, m_n % H, m_n / H) : 24'h0;
            check("model", {6'b0, wr_en, frame_done, pixel_out}, {6'b0, e_wr, m_done, e_pix});

            if (frame_done) begin
                last_count = wcount;
                wcount     = 0;
                frames++;
            end
            if (wr_en) begin
                if (wcount < NPIX) pix_log[wcount] = pixel_out;
                wcount++;
            end
            if (rst) wcount = 0;

            if (rst) begin
                m_run = 1'b0; m_mode = 0; m_n = 0; m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                if (!m_run) begin
                    if (enable) begin
                        m_run  = 1'b1;
                        m_mode = int'(mode);
                    end
                end else if (e_wr) begin
                    if (m_n == NPIX - 1) begin
                        m_n    = 0;
                        m_done = 1'b1;
                        if (enable) m_mode = int'(mode);
                        else        m_run  = 1'b0;
                    end else begin
                        m_n++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        while (wcount < n && budget > 0) begin
            step();
            budget--;
        end
        if (wcount < n) check("wait_writes_timeout", 32'(wcount), 32'(n));
    endtask

    task automatic wait_done(input int budget);
        int f0;
        f0 = frames;
        while (frames == f0 && budget > 0) begin
            step();
            budget--;
        end
        if (frames == f0) check("wait_done_timeout", 32'(frames), 32'(f0 + 1));
    endtask

    typedef struct {
        bit          r;
        bit          en;
        logic [1:0]  md;
        bit          full;
        bit          ewr;
        logic [23:0] epix;
        bit          edone;
    } vec_t;

    vec_t tab [8];

    initial begin
        tab[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 24'h000000, 1'b0};
        tab[1] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 24'h000000, 1'b0};
        tab[2] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 24'h000000, 1'b0};
        tab[3] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 24'hFFFFFF, 1'b0};
        tab[4] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 24'h000000, 1'b0};
        tab[5] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 24'h000000, 1'b0};
        tab[6] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 24'hFFFFFF, 1'b0};
        tab[7] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 24'hFFFFFF, 1'b0};

        // Hold reset for two cycles.
        rst = 1'b1;
        step();
        m_on = 1'b1;
        step();

        // Table: idle after reset, frame start, and a short stall.
        for (int i = 0; i < 8; i++) begin
            rst = tab[i].r; enable = tab[i].en; mode = tab[i].md; fifo_full = tab[i].full;
            @(negedge clk);
            check($sformatf("vec%0d", i), {6'b0, wr_en, frame_done, pixel_out},
                  {6'b0, tab[i].ewr, tab[i].edone, tab[i].epix});
            step();
        end

        // Bars: stall for five cycles at x=100, then resume on the same pixel.
        mode = 2'd0; fifo_full = 1'b0;
        wait_writes(100, 400);
        for (int i = 0; i < 5; i++) begin
            fifo_full = 1'b1;
            @(negedge clk);
            check("stall_wr_en", 32'(wr_en), 32'd0);
            step();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("resume_pixel", {7'b0, wr_en, pixel_out}, {7'b0, 1'b1, 24'h0000FF});
        step();
        wait_writes(H + 2, 400);
        check("bar_w0",   32'(pix_log[0]),     32'hFFFFFF);
        check("bar_w15",  32'(pix_log[15]),    32'hFFFFFF);
        check("bar_w16",  32'(pix_log[16]),    32'hFFFF00);
        check("bar_w100", 32'(pix_log[100]),   32'h0000FF);
        check("bar_w101", 32'(pix_log[101]),   32'h0000FF);
        check("bar_wlast",32'(pix_log[H - 1]), 32'h000000);
        check("bar_line1",32'(pix_log[H]),     32'hFFFFFF);

        // The mode changes to checker at y=10. The bars still run to the end of the frame.
        wait_writes(10 * H, 2 * NPIX);
        mode = 2'd1;
        wait_done(2 * NPIX);
        check("frame1_count",  32'(last_count),            32'(NPIX));
        check("frame1_y20",    32'(pix_log[20 * H + 20]),  32'hFFFF00);
        check("frame1_last",   32'(pix_log[NPIX - 1]),     32'h000000);

        // Frame 2 uses the checker, with random back-pressure. Gradient is queued for the next frame.
        mode = 2'd2;
        while (frames < 2 + 0 && 1'b0) step();
        begin
            int f0;
            int budget;
            f0 = frames;
            budget = 4 * NPIX;
            while (frames == f0 && budget > 0) begin
                fifo_full = ($urandom_range(0, 3) == 0);
                step();
                budget--;
            end
            if (frames == f0) check("frame2_timeout", 32'(frames), 32'(f0 + 1));
        end
        fifo_full = 1'b0;
        check("frame2_count",  32'(last_count),          32'(NPIX));
        check("check_8_0",     32'(pix_log[8]),          32'hFFFFFF);
        check("check_8_8",     32'(pix_log[8 * H + 8]),  32'h000000);
        check("check_0_9",     32'(pix_log[9 * H]),      32'hFFFFFF);

        // Frame 3 is the gradient. enable drops at y=20 and the frame must still complete.
        wait_writes(20 * H, 2 * NPIX);
        enable = 1'b0;
        wait_done(2 * NPIX);
        check("frame3_count",  32'(last_count),          32'(NPIX));
        check("grad_first",    32'(pix_log[0]),          32'h000080);
        check("grad_4_1",      32'(pix_log[H + 4]),      32'h010080);
        check("grad_last",     32'(pix_log[NPIX - 1]),   32'h1F1780);
        for (int i = 0; i < 50; i++) step();
        check("idle_no_writes", 32'(wcount), 32'd0);

        // Solid mode: reset in the middle of the frame, then restart from (0,0).
        enable = 1'b1; mode = 2'd3;
        wait_writes(20 * H + 5, 2 * NPIX);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        step();
        @(negedge clk);
        check("restart_pix", {7'b0, wr_en, pixel_out}, {7'b0, 1'b1, SOLID});
        step();
        wait_writes(3, 50);
        check("restart_log0", 32'(pix_log[0]), 32'(SOLID));

        // Random soak. The model checks every cycle.
        for (int i = 0; i < 15000; i++) begin
            fifo_full = ($urandom_range(0, 9) < 3);
            mode      = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1999) == 0) enable = ~enable;
            rst       = ($urandom_range(0, 4999) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
